// File: rtl/matmul_tile_scheduler_if.sv
// matmul_tile_scheduler_if: result-memory write port (stb/ack) driven by the tile scheduler
interface matmul_tile_scheduler_if #(parameter int N_LEN = 3) ();
  logic [N_LEN-1:0] z_row;
  logic [N_LEN-1:0] z_col;
  logic [31:0] z_data;
  logic z_stb;
  logic z_ack;
  modport master (output z_row, z_col, z_data, z_stb, input z_ack);
  modport slave (input z_row, z_col, z_data, z_stb, output z_ack);
endinterface

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: runs one row_col_multiplier over every MxM tile of an NxN product
module matmul_tile_scheduler #(
  parameter int N = 8,
  parameter int M = 4,
  localparam int NT = N / M,
  localparam int N_LEN = $clog2(N),
  localparam int M_LEN = $clog2(M),
  localparam int T_LEN = NT > 1 ? $clog2(NT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic [T_LEN-1:0] tile_row,
  output logic [T_LEN-1:0] tile_col,
  output logic rc_rst,
  output logic rc_start,
  input  logic rc_done,
  input  logic [M_LEN-1:0] rc_a_i,
  input  logic [N_LEN-1:0] rc_a_j,
  input  logic [N_LEN-1:0] rc_b_i,
  input  logic [M_LEN-1:0] rc_b_j,
  input  logic [31:0] rc_z_out,
  input  logic [M_LEN-1:0] rc_z_i,
  input  logic [M_LEN-1:0] rc_z_j,
  input  logic rc_z_stb,
  output logic rc_z_ack,
  output logic [31:0] rc_cur,
  output logic [N_LEN-1:0] a_row,
  output logic [N_LEN-1:0] a_col,
  output logic [N_LEN-1:0] b_row,
  output logic [N_LEN-1:0] b_col,
  output logic [N_LEN-1:0] cur_row,
  output logic [N_LEN-1:0] cur_col,
  input  logic [31:0] cur_data,
  matmul_tile_scheduler_if.master zb
);
  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, DRAIN, FIN} state_t;
  state_t state, next;
  logic [N_LEN-1:0] row_base, col_base;
  logic kill, last, drained, cap;
  assign row_base = N_LEN'(tile_row) << M_LEN;
  assign col_base = N_LEN'(tile_col) << M_LEN;
  assign a_row = row_base + N_LEN'(rc_a_i);
  assign a_col = rc_a_j;
  assign b_row = rc_b_i;
  assign b_col = col_base + N_LEN'(rc_b_j);
  assign cur_row = row_base + N_LEN'(rc_z_i);
  assign cur_col = col_base + N_LEN'(rc_z_j);
  assign rc_cur = cur_data;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign rc_rst = state == IDLE || state == CLEAR || state == FIN;
  assign rc_start = state == LAUNCH || state == RUN;
  assign kill = abort && state != IDLE;
  assign last = tile_row == T_LEN'(NT - 1) && tile_col == T_LEN'(NT - 1);
  assign drained = !zb.z_stb && !rc_z_stb;
  // rc_z_ack still high means the unit has not yet dropped the stb we just took
  assign cap = rc_z_stb && !zb.z_stb && !rc_z_ack;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start && !abort ? CLEAR : IDLE;
      CLEAR:   next = LAUNCH;
      LAUNCH:  next = RUN;
      RUN:     next = rc_done ? DRAIN : RUN;
      DRAIN:   next = drained ? (last ? FIN : CLEAR) : DRAIN;
      default: next = IDLE;
    endcase
    if (kill) next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tile_row <= '0;
      tile_col <= '0;
    end else begin
      state <= next;
      if (state == IDLE && next == CLEAR) begin
        tile_row <= '0;
        tile_col <= '0;
      end else if (state == DRAIN && next == CLEAR) begin
        tile_col <= tile_col == T_LEN'(NT - 1) ? '0 : tile_col + T_LEN'(1);
        if (tile_col == T_LEN'(NT - 1)) tile_row <= tile_row + T_LEN'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zb.z_stb <= 1'b0;
      zb.z_row <= '0;
      zb.z_col <= '0;
      zb.z_data <= '0;
      rc_z_ack <= 1'b0;
    end else if (kill) begin
      zb.z_stb <= 1'b0;
      rc_z_ack <= 1'b0;
    end else begin
      rc_z_ack <= cap;
      if (cap) begin
        zb.z_stb <= 1'b1;
        zb.z_row <= cur_row;
        zb.z_col <= cur_col;
        zb.z_data <= rc_z_out;
      end else if (zb.z_ack) zb.z_stb <= 1'b0;
    end
  end
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: directed scenarios for the tile scheduler with a behavioural unit and result memory
module tb_matmul_tile_scheduler;
  localparam int NL = 3, ML = 2, TL = 1;
  logic clk = 1'b0, rst, start, abort, rc_done, rc_z_stb;
  logic busy, done, rc_rst, rc_start, rc_z_ack;
  logic [TL-1:0] tile_row, tile_col;
  logic [ML-1:0] rc_a_i, rc_b_j, rc_z_i, rc_z_j;
  logic [NL-1:0] rc_a_j, rc_b_i, a_row, a_col, b_row, b_col, cur_row, cur_col;
  logic [31:0] rc_z_out, rc_cur, cur_data;
  logic ack_hold;
  int tests = 0, fails = 0, done_cnt = 0, wcount = 0, wc_at_done = 0;
  int A[8][8], B[8][8];
  logic [31:0] zm[8][8];
  logic [NL-1:0] lw_row, lw_col;
  logic [31:0] lw_data;
  matmul_tile_scheduler_if #(.N_LEN(NL)) zb ();
  matmul_tile_scheduler #(.N(8), .M(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .tile_row(tile_row), .tile_col(tile_col), .rc_rst(rc_rst), .rc_start(rc_start),
    .rc_done(rc_done), .rc_a_i(rc_a_i), .rc_a_j(rc_a_j), .rc_b_i(rc_b_i), .rc_b_j(rc_b_j),
    .rc_z_out(rc_z_out), .rc_z_i(rc_z_i), .rc_z_j(rc_z_j), .rc_z_stb(rc_z_stb),
    .rc_z_ack(rc_z_ack), .rc_cur(rc_cur), .a_row(a_row), .a_col(a_col), .b_row(b_row),
    .b_col(b_col), .cur_row(cur_row), .cur_col(cur_col), .cur_data(cur_data), .zb(zb)
  );
  always #5 clk = ~clk;
  initial begin
    zb.z_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (zb.z_ack) begin
        zm[zb.z_row][zb.z_col] = zb.z_data;
        lw_row = zb.z_row;
        lw_col = zb.z_col;
        lw_data = zb.z_data;
        wcount++;
      end
      zb.z_ack = zb.z_stb && !ack_hold;
    end
  end
  initial forever begin
    @(negedge clk);
    if (done) begin
      done_cnt++;
      wc_at_done = wcount;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired: bench did not finish");
    $fatal(1);
  end
  function automatic logic cond(input int k);
    return k == 0 ? (rc_start && !rc_rst) : k == 1 ? rc_rst : k == 2 ? rc_z_ack : done;
  endfunction
  task automatic wait_for(input int k, input string nm);
    int n = 0;
    @(negedge clk);
    while (!cond(k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cond(k)) begin
      tests++;
      fails++;
      $display("FAIL timeout_%s got no event after %0d cycles, required event", nm, n);
    end
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic do_abort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
  endtask
  task automatic emit(input int zi, input int zj, input logic [31:0] d);
    rc_z_i = ML'(zi);
    rc_z_j = ML'(zj);
    rc_z_out = d;
    rc_z_stb = 1'b1;
    wait_for(2, "rc_z_ack");
    rc_z_stb = 1'b0;
  endtask
  task automatic finish_tile();
    rc_done = 1'b1;
    wait_for(1, "rc_rst");
    rc_done = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; rc_done = 0; rc_z_stb = 0; ack_hold = 0;
    rc_a_i = 0; rc_b_j = 0; rc_z_i = 0; rc_z_j = 0; rc_a_j = 0; rc_b_i = 0;
    rc_z_out = 0; cur_data = 32'hC0DE_0000;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, rc_rst, rc_start, rc_z_ack, zb.z_stb} !== 6'b001000) begin
      fails++;
      $display("FAIL reset_ctrl got %b required %b", {busy, done, rc_rst, rc_start, rc_z_ack, zb.z_stb}, 6'b001000);
    end
    tests++;
    if ({tile_row, tile_col, zb.z_row, zb.z_col, zb.z_data} !== '0) begin
      fails++;
      $display("FAIL reset_regs got %h required 0", {tile_row, tile_col, zb.z_row, zb.z_col, zb.z_data});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_busy got %b required 0", busy);
    end
  endtask
  task automatic test_functional();
    int acc, d0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 8 * i + j;
        zm[i][j] = 32'hFFFF_FFFF;
      end
    wcount = 0;
    d0 = done_cnt;
    pulse_start();
    for (int t = 0; t < 4; t++) begin
      wait_for(0, "run");
      tests++;
      if ({tile_row, tile_col} !== 2'(t)) begin
        fails++;
        $display("FAIL tile_order got %b required %b", {tile_row, tile_col}, 2'(t));
      end
      for (int zi = 0; zi < 4; zi++)
        for (int zj = 0; zj < 4; zj++) begin
          acc = 0;
          for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rc_a_i = ML'(zi); rc_b_j = ML'(zj); rc_a_j = NL'(k); rc_b_i = NL'(k);
            #1 acc += A[a_row][a_col] * B[b_row][b_col];
          end
          @(negedge clk);
          emit(zi, zj, 32'(acc));
        end
      finish_tile();
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL func_done_pulses got %0d required 1", done_cnt - d0);
    end
    tests++;
    if (wc_at_done !== 64 || wcount !== 64) begin
      fails++;
      $display("FAIL func_writes got %0d (at done %0d) required 64", wcount, wc_at_done);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL func_busy_after got %b required 0", busy);
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        tests++;
        if (zm[i][j] !== 32'(8 * i + j)) begin
          fails++;
          $display("FAIL func_z[%0d][%0d] got %0d required %0d", i, j, zm[i][j], 8 * i + j);
        end
      end
  endtask
  task automatic test_translation();
    pulse_start();
    wait_for(0, "run");
    finish_tile();
    wait_for(0, "run");
    finish_tile();
    wait_for(0, "run");
    tests++;
    if ({tile_row, tile_col} !== 2'b10) begin
      fails++;
      $display("FAIL xlat_tile got %b required 10", {tile_row, tile_col});
    end
    rc_a_i = 2'd3; rc_b_j = 2'd2; rc_z_i = 2'd2; rc_z_j = 2'd1; rc_a_j = 3'd5; rc_b_i = 3'd4;
    cur_data = 32'h5A5A_1234;
    #1;
    tests++;
    if ({a_row, a_col, b_row, b_col, cur_row, cur_col} !== {3'd7, 3'd5, 3'd4, 3'd2, 3'd6, 3'd1}) begin
      fails++;
      $display("FAIL xlat_addr got a=%0d,%0d b=%0d,%0d cur=%0d,%0d required a=7,5 b=4,2 cur=6,1",
               a_row, a_col, b_row, b_col, cur_row, cur_col);
    end
    tests++;
    if (rc_cur !== 32'h5A5A_1234) begin
      fails++;
      $display("FAIL xlat_rc_cur got %h required 5a5a1234", rc_cur);
    end
    @(negedge clk);
    emit(2, 1, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    tests++;
    if ({lw_row, lw_col, lw_data} !== {3'd6, 3'd1, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL xlat_write got row=%0d col=%0d data=%h required 6,1,deadbeef", lw_row, lw_col, lw_data);
    end
    finish_tile();
    wait_for(0, "run");
    tests++;
    if ({tile_row, tile_col} !== 2'b11) begin
      fails++;
      $display("FAIL xlat_last_tile got %b required 11", {tile_row, tile_col});
    end
    finish_tile();
    repeat (2) @(negedge clk);
  endtask
  task automatic test_backpressure();
    int acks = 0, unstable = 0;
    pulse_start();
    wait_for(0, "run");
    ack_hold = 1'b1;
    rc_z_i = 2'd1; rc_z_j = 2'd3; rc_z_out = 32'h1111_2222; rc_z_stb = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rc_z_ack) acks++;
      if (zb.z_data !== 32'h1111_2222 || zb.z_stb !== 1'b1) unstable++;
      rc_z_out = $urandom;
    end
    rc_z_stb = 1'b0;
    tests++;
    if (acks !== 1) begin
      fails++;
      $display("FAIL bp_ack_pulses got %0d required 1", acks);
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("FAIL bp_stable got %0d unstable cycles required 0", unstable);
    end
    tests++;
    if ({zb.z_row, zb.z_col} !== {3'd1, 3'd3}) begin
      fails++;
      $display("FAIL bp_addr got %0d,%0d required 1,3", zb.z_row, zb.z_col);
    end
    rc_done = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({busy, rc_rst, rc_start, tile_col} !== 4'b1000) begin
      fails++;
      $display("FAIL bp_hold_drain got %b required 1000", {busy, rc_rst, rc_start, tile_col});
    end
    ack_hold = 1'b0;
    wait_for(1, "bp_clear");
    rc_done = 1'b0;
    tests++;
    if ({tile_row, tile_col, lw_data} !== {1'b0, 1'b1, 32'h1111_2222}) begin
      fails++;
      $display("FAIL bp_advance got tile=%b%b data=%h required tile=01 data=11112222", tile_row, tile_col, lw_data);
    end
    do_abort();
  endtask
  task automatic test_stale_done();
    rc_done = 1'b1;
    pulse_start();
    tests++;
    if ({rc_rst, rc_start} !== 2'b10) begin
      fails++;
      $display("FAIL stale_clear got rc_rst,rc_start=%b required 10", {rc_rst, rc_start});
    end
    @(negedge clk);
    rc_done = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({rc_rst, rc_start, tile_col} !== 3'b010) begin
      fails++;
      $display("FAIL stale_still_run got %b required 010", {rc_rst, rc_start, tile_col});
    end
    rc_done = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, rc_rst, rc_start} !== 3'b100) begin
      fails++;
      $display("FAIL stale_fresh_done got %b required 100", {busy, rc_rst, rc_start});
    end
    wait_for(1, "stale_clear2");
    rc_done = 1'b0;
    tests++;
    if (tile_col !== 1'b1) begin
      fails++;
      $display("FAIL stale_advance got tile_col=%b required 1", tile_col);
    end
    do_abort();
  endtask
  task automatic test_abort();
    int d0, w0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle_start got busy=%b required 0", busy);
    end
    pulse_start();
    wait_for(0, "run");
    finish_tile();
    wait_for(0, "run");
    ack_hold = 1'b1;
    emit(0, 2, 32'h0000_ABCD);
    tests++;
    if (zb.z_stb !== 1'b1) begin
      fails++;
      $display("FAIL abort_pending got z_stb=%b required 1", zb.z_stb);
    end
    d0 = done_cnt;
    w0 = wcount;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({busy, rc_rst, rc_start, rc_z_ack, zb.z_stb, tile_row, tile_col} !== 7'b0100001) begin
      fails++;
      $display("FAIL abort_state got %b required 0100001", {busy, rc_rst, rc_start, rc_z_ack, zb.z_stb, tile_row, tile_col});
    end
    ack_hold = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (done_cnt !== d0 || wcount !== w0) begin
      fails++;
      $display("FAIL abort_no_done got done=%0d writes=%0d required %0d,%0d", done_cnt, wcount, d0, w0);
    end
    pulse_start();
    tests++;
    if ({busy, tile_row, tile_col} !== 3'b100) begin
      fails++;
      $display("FAIL abort_restart got %b required 100", {busy, tile_row, tile_col});
    end
    do_abort();
  endtask
  task automatic test_async_rst();
    ack_hold = 1'b1;
    pulse_start();
    wait_for(0, "run");
    finish_tile();
    wait_for(0, "run");
    emit(3, 3, 32'h0000_0077);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, rc_rst, rc_start, rc_z_ack, zb.z_stb} !== 6'b001000) begin
      fails++;
      $display("FAIL arst_ctrl got %b required 001000", {busy, done, rc_rst, rc_start, rc_z_ack, zb.z_stb});
    end
    tests++;
    if ({tile_row, tile_col, zb.z_row, zb.z_col, zb.z_data} !== '0) begin
      fails++;
      $display("FAIL arst_regs got %h required 0", {tile_row, tile_col, zb.z_row, zb.z_col, zb.z_data});
    end
    @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    pulse_start();
    wait_for(0, "run");
    finish_tile();
    wait_for(0, "run");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tests++;
    if ({rc_rst, rc_start, tile_row, tile_col} !== 4'b0101) begin
      fails++;
      $display("FAIL busy_start_ignored got %b required 0101", {rc_rst, rc_start, tile_row, tile_col});
    end
    do_abort();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL final_idle got busy=%b required 0", busy);
    end
  endtask
  initial begin
    test_reset();
    test_functional();
    test_translation();
    test_backpressure();
    test_stale_done();
    test_abort();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
